// File: rtl/matrix_xform_pkg.sv
// rtl/matrix_xform_pkg.sv - shared codes for the forward/inverse 2D transform blocks
package matrix_xform_pkg;

    localparam int XF_FRAC_BITS = 8;

    localparam logic [1:0] XF_ROTATE    = 2'b00;
    localparam logic [1:0] XF_SCALE     = 2'b01;
    localparam logic [1:0] XF_TRANSLATE = 2'b10;
    localparam logic [1:0] XF_IDENTITY  = 2'b11;

    // 0/90/180 fit in param1[7:0]; 270 needs bit 8, so it is decoded from param1[8:0]
    localparam logic [7:0] ANG_0   = 8'd0;
    localparam logic [7:0] ANG_90  = 8'd90;
    localparam logic [7:0] ANG_180 = 8'd180;
    localparam logic [8:0] ANG_270 = 9'd270;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXEC   = 3'd1;
    localparam logic [2:0] ST_OUTPUT = 3'd2;
    localparam logic [2:0] ST_DIV_X  = 3'd3;
    localparam logic [2:0] ST_DIV_Y  = 3'd4;

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - unsigned restoring divider, one quotient bit per cycle
module serial_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DATA_WIDTH+FRAC_BITS-1:0] dividend,
    input  logic [DATA_WIDTH:0]             divisor,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH+FRAC_BITS-1:0] quotient
);

    localparam int NW = DATA_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0]         q_reg;
    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH:0]   dsr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] diff;

    // rem < dsr always holds, so the msb of diff is exactly the borrow
    assign shifted  = {rem, q_reg[NW-1]};
    assign diff     = shifted - {1'b0, dsr};
    assign quotient = q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
            rem   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            q_reg <= dividend;
            rem   <= '0;
            dsr   <= divisor;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            rem   <= diff[DATA_WIDTH+1] ? shifted[DATA_WIDTH:0] : diff[DATA_WIDTH:0];
            q_reg <= {q_reg[NW-2:0], ~diff[DATA_WIDTH+1]};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(NW - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_inverse_transform.sv
// rtl/matrix_inverse_transform.sv - inverse of the 2D rotate/scale/translate transform
module matrix_inverse_transform
    import matrix_xform_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = XF_FRAC_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     x_in,
    input  logic [DATA_WIDTH-1:0]     y_in,
    input  logic [1:0]                transform_type,
    input  logic [DATA_WIDTH-1:0]     param1,
    input  logic [DATA_WIDTH-1:0]     param2,
    output logic [DATA_WIDTH-1:0]     x_out,
    output logic [DATA_WIDTH-1:0]     y_out,
    output logic [2*DATA_WIDTH-1:0]   combined_out,
    output logic                      transform_valid,
    output logic                      transform_done,
    output logic                      busy,
    output logic                      inv_error
);

    localparam int NW = DATA_WIDTH + FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [2:0]            state;
    logic [1:0]            op_type;
    logic [DATA_WIDTH-1:0] xq, yq, p1_q, p2_q;
    logic [NW-1:0]         qx, qy;

    logic                  div_start, div_busy, div_done;
    logic [NW-1:0]         div_dividend, div_quotient;
    logic [DATA_WIDTH:0]   div_divisor;
    logic                  scale_go;

    function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Magnitude quotient back to signed with clamping; 2^(DW-1) is representable only when negative
    function automatic logic [DATA_WIDTH-1:0] sat_q(input logic [NW-1:0] q, input logic neg);
        logic [NW-1:0] lim;
        lim = NW'(S_MIN);
        if (neg)
            return (q >= lim) ? S_MIN : -q[DATA_WIDTH-1:0];
        else
            return (q >= lim) ? S_MAX : q[DATA_WIDTH-1:0];
    endfunction

    assign busy     = (state != ST_IDLE);
    assign scale_go = start && (transform_type == XF_SCALE) && (param1 != '0);

    // x division launches straight from the live inputs so it overlaps the operand latch
    always_comb begin
        div_start    = 1'b0;
        div_dividend = {mag(yq), {FRAC_BITS{1'b0}}};
        div_divisor  = {1'b0, mag(p1_q)};
        if (state == ST_IDLE) begin
            div_start    = scale_go;
            div_dividend = {mag(x_in), {FRAC_BITS{1'b0}}};
            div_divisor  = {1'b0, mag(param1)};
        end else if (state == ST_DIV_X) begin
            div_start    = div_done && !div_busy;
        end
    end

    serial_divider #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            op_type         <= XF_IDENTITY;
            xq              <= '0;
            yq              <= '0;
            p1_q            <= '0;
            p2_q            <= '0;
            qx              <= '0;
            qy              <= '0;
            x_out           <= '0;
            y_out           <= '0;
            combined_out    <= '0;
            transform_valid <= 1'b0;
            transform_done  <= 1'b0;
            inv_error       <= 1'b0;
        end else begin
            transform_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_type        <= transform_type;
                        xq             <= x_in;
                        yq             <= y_in;
                        p1_q           <= param1;
                        p2_q           <= param2;
                        transform_done <= 1'b0;
                        state          <= scale_go ? ST_DIV_X : ST_EXEC;
                    end
                end
                ST_DIV_X: begin
                    if (div_done && !div_busy) begin
                        qx    <= div_quotient;
                        state <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done && !div_busy) begin
                        qy    <= div_quotient;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    x_out <= xq;
                    y_out <= yq;
                    case (op_type)
                        XF_ROTATE: begin
                            if (p1_q[7:0] == ANG_90) begin
                                x_out <= yq;
                                y_out <= -xq;
                            end else if (p1_q[7:0] == ANG_180) begin
                                x_out <= -xq;
                                y_out <= -yq;
                            end else if (p1_q[7:0] != ANG_0 && p1_q[8:0] == ANG_270) begin
                                x_out <= -yq;
                                y_out <= xq;
                            end
                        end
                        XF_SCALE: begin
                            if (p1_q != '0) begin
                                x_out <= sat_q(qx, xq[DATA_WIDTH-1] ^ p1_q[DATA_WIDTH-1]);
                                y_out <= sat_q(qy, yq[DATA_WIDTH-1] ^ p1_q[DATA_WIDTH-1]);
                            end
                        end
                        XF_TRANSLATE: begin
                            x_out <= xq - p1_q;
                            y_out <= yq - p2_q;
                        end
                        default: ;
                    endcase
                    state <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    combined_out    <= {y_out, x_out};
                    transform_valid <= 1'b1;
                    transform_done  <= 1'b1;
                    inv_error       <= (op_type == XF_SCALE) && (p1_q == '0);
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_inverse_transform.sv
// tb/tb_matrix_inverse_transform.sv - self-checking bench for matrix_inverse_transform
module tb_matrix_inverse_transform;
    import matrix_xform_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  ttype = 2'b00;
    logic [15:0] x_in = '0, y_in = '0, p1 = '0, p2 = '0;
    logic [15:0] x_out, y_out;
    logic [31:0] combined_out;
    logic        transform_valid, transform_done, busy, inv_error;

    matrix_inverse_transform #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .x_in            (x_in),
        .y_in            (y_in),
        .transform_type  (ttype),
        .param1          (p1),
        .param2          (p2),
        .x_out           (x_out),
        .y_out           (y_out),
        .combined_out    (combined_out),
        .transform_valid (transform_valid),
        .transform_done  (transform_done),
        .busy            (busy),
        .inv_error       (inv_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          k;
        int          exp;
        logic [15:0] x;
        logic [15:0] y;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] last_x, last_y;
    logic [31:0] last_c;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] div_model(input logic [15:0] v, input logic [15:0] s);
        longint vi, si, q;
        vi = longint'($signed(v));
        si = longint'($signed(s));
        q  = ((vi < 0 ? -vi : vi) * 256) / (si < 0 ? -si : si);
        if ((vi < 0) != (si < 0)) q = -q;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic void model(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] xv, input logic [15:0] yv,
                                  output logic [15:0] ex, output logic [15:0] ey,
                                  output logic ee, output int lat);
        ex = xv; ey = yv; ee = 1'b0; lat = 2;
        case (t)
            2'b00: begin
                if (a[7:0] == 8'd90)       begin ex = yv;  ey = -xv; end
                else if (a[7:0] == 8'd180) begin ex = -xv; ey = -yv; end
                else if (a[7:0] != 8'd0 && a[8:0] == 9'd270) begin ex = -yv; ey = xv; end
            end
            2'b01: begin
                if (a == 16'h0) ee = 1'b1;
                else begin
                    ex  = div_model(xv, a);
                    ey  = div_model(yv, a);
                    lat = 2 + 2 * (16 + 8 + 1);
                end
            end
            2'b10: begin ex = xv - a; ey = yv - b; end
            default: ;
        endcase
    endfunction

    // Per-cycle checker: valid/busy/done timing plus result values on every valid pulse
    initial begin : compare
        logic ev, eb;
        forever begin
            @(posedge clk);
            #2;
            ev = (exp_q.size() > 0) && (cyc == exp_q[0].exp);
            eb = (exp_q.size() > 0) && (cyc >= exp_q[0].k) && (cyc < exp_q[0].exp);
            chk("valid", {31'b0, transform_valid}, {31'b0, ev});
            chk("busy", {31'b0, busy}, {31'b0, eb});
            if (exp_q.size() > 0 && cyc == exp_q[0].k)
                chk("done_clear", {31'b0, transform_done}, 32'd0);
            if (ev) begin
                chk("x_out", {16'b0, x_out}, {16'b0, exp_q[0].x});
                chk("y_out", {16'b0, y_out}, {16'b0, exp_q[0].y});
                chk("combined", combined_out, {exp_q[0].y, exp_q[0].x});
                chk("inv_error", {31'b0, inv_error}, {31'b0, exp_q[0].err});
                chk("done_set", {31'b0, transform_done}, 32'd1);
                last_x   = x_out;
                last_y   = y_out;
                last_c   = combined_out;
                last_err = inv_error;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] xv, input logic [15:0] yv, output int k);
        exp_t e;
        int   lat;
        model(t, a, b, xv, yv, e.x, e.y, e.err, lat);
        @(negedge clk);
        ttype = t; p1 = a; p2 = b; x_in = xv; y_in = yv; start = 1'b1;
        e.k   = cyc + 1;
        e.exp = cyc + 1 + lat;
        k     = e.k;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        ttype = 2'($urandom); p1 = 16'($urandom); p2 = 16'($urandom);
        x_in  = 16'($urandom); y_in = 16'($urandom);
    endtask

    task automatic wait_done(input bit noise);
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                start = 1'b0;
                break;
            end
            start = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL timeout: no transform_valid within 200 cycles");
                exp_q.delete();
                start = 1'b0;
                break;
            end
        end
    endtask

    task automatic run(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] xv, input logic [15:0] yv, input bit noise);
        int k;
        issue(t, a, b, xv, yv, k);
        wait_done(noise);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int          k;
        logic [15:0] mx, my;
        logic        me;
        int          ml;
        logic [15:0] ptab [8];

        model(XF_SCALE, 16'h0200, 16'h0, 16'd100, -16'sd7, mx, my, me, ml);
        chk("model_scale_x", {16'b0, mx}, 32'd50);
        chk("model_scale_y", {16'b0, my}, 32'h0000FFFD);
        chk("model_scale_lat", ml, 32'd52);
        model(XF_ROTATE, 16'd270, 16'h0, 16'd7, 16'd9, mx, my, me, ml);
        chk("model_rot270", {my, mx}, {16'd7, 16'hFFF7});

        repeat (3) @(negedge clk);
        chk("rst_x", {16'b0, x_out}, 32'd0);
        chk("rst_comb", combined_out, 32'd0);
        chk("rst_flags", {28'b0, transform_valid, transform_done, busy, inv_error}, 32'd0);
        rst = 1'b0;

        run(XF_ROTATE, 16'd90, 16'h0, 16'd5, -16'sd3, 1'b0);
        chk("t1_comb", last_c, 32'hFFFBFFFD);
        repeat (3) @(negedge clk);
        chk("t1_done_hold", {31'b0, transform_done}, 32'd1);

        run(XF_SCALE, 16'h0200, 16'h0, 16'd100, -16'sd7, 1'b0);
        chk("t2_xy", {last_y, last_x}, {16'hFFFD, 16'd50});

        run(XF_TRANSLATE, 16'd10, -16'sd20, 16'h7FFF, 16'd5, 1'b0);
        chk("t3_xy", {last_y, last_x}, {16'd25, 16'h7FF5});
        run(XF_TRANSLATE, 16'd1, 16'd0, 16'h8000, 16'd0, 1'b0);
        chk("t3_wrap", {16'b0, last_x}, 32'h7FFF);

        run(XF_SCALE, 16'h0000, 16'h0, 16'd12, 16'd34, 1'b0);
        chk("t4_err", {31'b0, last_err}, 32'd1);
        chk("t4_xy", {last_y, last_x}, {16'd34, 16'd12});
        run(XF_TRANSLATE, 16'd0, 16'd0, 16'd1, 16'd2, 1'b0);
        chk("t4_err_clr", {31'b0, last_err}, 32'd0);

        run(XF_SCALE, 16'h0001, 16'h0, 16'd1000, -16'sd1000, 1'b0);
        chk("t5_sat", {last_y, last_x}, {16'h8000, 16'h7FFF});

        run(XF_SCALE, 16'hFF00, 16'h0, 16'h8000, 16'd3, 1'b0);
        chk("t5_min_neg", {last_y, last_x}, {16'hFFFD, 16'h7FFF});

        run(XF_ROTATE, 16'd270, 16'h0, 16'h8000, 16'd4, 1'b0);
        chk("rot270", {last_y, last_x}, {16'h8000, 16'hFFFC});

        // ignored second start mid-divide
        issue(XF_SCALE, 16'h0180, 16'h0, 16'd300, -16'sd50, k);
        while (cyc < k + 9) @(negedge clk);
        ttype = XF_ROTATE; p1 = 16'd90; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);

        // reset in the middle of a scale op
        issue(XF_SCALE, 16'h0300, 16'h0, 16'd700, 16'd800, k);
        while (cyc < k + 19) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t6_rst_xy", {y_out, x_out}, 32'd0);
        chk("t6_rst_comb", combined_out, 32'd0);
        chk("t6_rst_flags", {28'b0, transform_valid, transform_done, busy, inv_error}, 32'd0);
        rst = 1'b0;
        run(XF_ROTATE, 16'd180, 16'h0, 16'd3, 16'd4, 1'b0);
        chk("t6_rot180", {last_y, last_x}, {16'hFFFC, 16'hFFFD});

        ptab[0] = 16'd0;    ptab[1] = 16'd90;   ptab[2] = 16'd180;  ptab[3] = 16'd270;
        ptab[4] = 16'h0100; ptab[5] = 16'hFE80; ptab[6] = 16'h0003; ptab[7] = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ptab[$urandom_range(0, 7)];
            run(2'($urandom), a, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
